// File: rtl/seq_detect_1011_pkg.sv
// Shared definitions for the 1011 sequence detector: state encodings and pattern.
package seq_detect_1011_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detect_1011_cells.sv
// Basic cell library for the detector: async-reset enabled flop and 2-input gates.
module dff_ar #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  always_comb y = a & b;
endmodule

module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  always_comb y = a | b;
endmodule

module not1 (
  input  logic a,
  output logic y
);
  always_comb y = ~a;
endmodule

module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  always_comb y = a ^ b;
endmodule

// File: rtl/seq_detect_1011.sv
// Overlapping 1011 detector with registered match pulse and saturating hit counter,
// built structurally from dff_ar flops and basic gates.
module seq_detect_1011
  import seq_detect_1011_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [1:0] RESET_STATE = S0;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             match_q;
  logic             match_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_sum;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   carry;

  logic bit_n, s0_n, clr_n, sat_n;
  logic t_b_s1, t_set, t_ret, n1;
  logic in_s3, det, det_v;
  logic state_en, cnt_inc, cnt_en;

  // State register
  for (genvar i = 0; i < 2; i++) begin : g_state
    dff_ar #(.RST_VAL(RESET_STATE[i])) u_st (
      .clk(clk), .rst(rst), .en(state_en), .d(state_d[i]), .q(state_q[i])
    );
  end

  dff_ar #(.RST_VAL(1'b0)) u_match (
    .clk(clk), .rst(rst), .en(1'b1), .d(match_d), .q(match_q)
  );

  for (genvar i = 0; i < CNT_W; i++) begin : g_cnt
    dff_ar #(.RST_VAL(1'b0)) u_cnt (
      .clk(clk), .rst(rst), .en(cnt_en), .d(count_d[i]), .q(count_q[i])
    );
  end

  // Next-state logic. With this encoding next[0] is simply the incoming bit;
  // next[1] is set by S2 on 1 or by S1/S3 on 0. All four codes are legal.
  not1 u_nbit (.a(in_bit),     .y(bit_n));
  not1 u_ns0  (.a(state_q[0]), .y(s0_n));
  not1 u_nclr (.a(clear),      .y(clr_n));

  and2 u_t1  (.a(in_bit), .b(state_q[1]), .y(t_b_s1));
  and2 u_t2  (.a(t_b_s1), .b(s0_n),       .y(t_set));
  and2 u_t3  (.a(bit_n),  .b(state_q[0]), .y(t_ret));
  or2  u_n1  (.a(t_set),  .b(t_ret),      .y(n1));

  and2 u_sd1 (.a(n1),     .b(clr_n), .y(state_d[1]));
  and2 u_sd0 (.a(in_bit), .b(clr_n), .y(state_d[0]));
  or2  u_sen (.a(in_valid), .b(clear), .y(state_en));

  // Detection: valid 1 while in S3, suppressed by clear
  and2 u_s3  (.a(state_q[1]), .b(state_q[0]), .y(in_s3));
  and2 u_det (.a(in_s3),      .b(in_bit),     .y(det));
  and2 u_dv  (.a(det),        .b(in_valid),   .y(det_v));
  and2 u_md  (.a(det_v),      .b(clr_n),      .y(match_d));

  // Ripple incrementer; the final carry doubles as the all-ones (saturation) decode
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < CNT_W; i++) begin : g_inc
    and2 u_c (.a(carry[i]),   .b(count_q[i]), .y(carry[i+1]));
    xor2 u_s (.a(count_q[i]), .b(carry[i]),   .y(count_sum[i]));
    and2 u_d (.a(count_sum[i]), .b(clr_n),    .y(count_d[i]));
  end

  not1 u_nsat (.a(carry[CNT_W]), .y(sat_n));
  and2 u_inc  (.a(match_d), .b(sat_n), .y(cnt_inc));
  or2  u_cen  (.a(cnt_inc), .b(clear), .y(cnt_en));

  // Outputs
  always_comb begin
    match = match_q;
    count = count_q;
    sat   = carry[CNT_W];
  end

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed self-checking bench for seq_detect_1011 (CNT_W = 4).
module tb_seq_detect_1011;
  import seq_detect_1011_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clear = 1'b0;
  logic             match;
  logic [CNT_W-1:0] count;
  logic             sat;

  int tests = 0;
  int fails = 0;

  seq_detect_1011 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .match(match), .count(count), .sat(sat)
  );

  always #5 clk = ~clk;

  // Present one input cycle at the falling edge, then settle just after the rising edge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    #2;
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (match !== 1'b0 || count !== 4'd0 || sat !== 1'b0) begin
      fails++;
      $display("FAIL reset: match=%b count=%0d sat=%b, required 0/0/0", match, count, sat);
    end
    do_reset();
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0);
      tests++;
      if (match !== exp[i]) begin
        fails++;
        $display("FAIL overlap bit%0d: match=%b, required %b", 7 - i, match, exp[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (count !== 4'd2 || sat !== 1'b0 || match !== 1'b0) begin
      fails++;
      $display("FAIL overlap final: count=%0d sat=%b match=%b, required 2/0/0", count, sat, match);
    end
  endtask

  task automatic test_s3_zero();
    logic [5:0] bits = 6'b101011;
    logic [5:0] exp  = 6'b000001;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0);
      tests++;
      if (match !== exp[i]) begin
        fails++;
        $display("FAIL s3_zero bit%0d: match=%b, required %b", 6 - i, match, exp[i]);
      end
    end
    tests++;
    if (count !== 4'd1) begin
      fails++;
      $display("FAIL s3_zero count: count=%0d, required 1", count);
    end
  endtask

  task automatic test_gap();
    logic [3:0] pat = PATTERN;
    do_reset();
    for (int i = 3; i >= 1; i--) step(1'b1, pat[i], 1'b0);
    for (int g = 0; g < 5; g++) begin
      step(1'b0, 1'b1, 1'b0);
      tests++;
      if (match !== 1'b0) begin
        fails++;
        $display("FAIL gap cycle%0d: match=%b, required 0", g, match);
      end
    end
    step(1'b1, pat[0], 1'b0);
    tests++;
    if (match !== 1'b1 || count !== 4'd1) begin
      fails++;
      $display("FAIL gap last: match=%b count=%0d, required 1/1", match, count);
    end
    step(1'b0, 1'b1, 1'b0);
    tests++;
    if (match !== 1'b0 || count !== 4'd1) begin
      fails++;
      $display("FAIL gap hold: match=%b count=%0d, required 0/1", match, count);
    end
  endtask

  task automatic test_saturation();
    int unsigned exp_cnt;
    int pulses = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if (match !== 1'b0) begin
        fails++;
        $display("FAIL sat_gap det%0d: match=%b, required 0", k, match);
      end
      step(1'b1, 1'b1, 1'b0);
      exp_cnt = (k > 15) ? 15 : k;
      if (match === 1'b1) pulses++;
      tests++;
      if (match !== 1'b1 || count !== exp_cnt[CNT_W-1:0] || sat !== (k >= 15)) begin
        fails++;
        $display("FAIL sat det%0d: match=%b count=%0d sat=%b, required 1/%0d/%b",
                 k, match, count, sat, exp_cnt, (k >= 15));
      end
    end
    tests++;
    if (pulses != 18) begin
      fails++;
      $display("FAIL sat pulses: got %0d, required 18", pulses);
    end
  endtask

  task automatic test_clear();
    logic [9:0] bits = 10'b1011011011;
    do_reset();
    for (int i = 9; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (count !== 4'd3) begin
      fails++;
      $display("FAIL clear setup: count=%0d, required 3", count);
    end
    step(1'b1, 1'b1, 1'b1);
    tests++;
    if (match !== 1'b0 || count !== 4'd0 || sat !== 1'b0) begin
      fails++;
      $display("FAIL clear: match=%b count=%0d sat=%b, required 0/0/0", match, count, sat);
    end
    // From S0 "011" must not match; from S3 or S1 (cleared bit kept) it would.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (match !== 1'b0 || count !== 4'd0) begin
      fails++;
      $display("FAIL clear state: match=%b count=%0d, required 0/0", match, count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (count !== 4'd5) begin
      fails++;
      $display("FAIL async setup: count=%0d, required 5", count);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (match !== 1'b0 || count !== 4'd0 || sat !== 1'b0) begin
      fails++;
      $display("FAIL async reset: match=%b count=%0d sat=%b, required 0/0/0", match, count, sat);
    end
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (match !== 1'b0) begin
      fails++;
      $display("FAIL async after: match=%b, required 0", match);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (match !== 1'b1 || count !== 4'd1) begin
      fails++;
      $display("FAIL async restart: match=%b count=%0d, required 1/1", match, count);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_s3_zero();
    test_gap();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detect_1011.md
SEQ_DETECT_1011 -- requirements
Module: seq_detect_1011

Interface
REQ-001 Parameter CNT_W, default 4, SHALL set the width of the detection counter.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  high SHALL mean in_bit is a new stream bit this cycle.
REQ-005 in_bit  input  1  serial data bit, sampled only when in_valid=1.
REQ-006 clear  input  1  synchronous clear of detector state, counter and match.
REQ-007 match  output  1  registered one-cycle pulse marking one detection of 1011.
REQ-008 count  output  CNT_W  registered saturating number of detections since reset/clear.
REQ-009 sat  output  1  high SHALL mean count equals 2^CNT_W-1.

Function
REQ-010 FSM states SHALL be S0 (no prefix), S1 ("1"), S2 ("10"), S3 ("101"), encoded in 2 bits.
REQ-011 Transitions on a valid bit SHALL be: S0: 1->S1, 0->S0; S1: 1->S1, 0->S2; S2: 1->S3, 0->S0; S3: 1->S1 with detection, 0->S2.
REQ-012 Detection SHALL be overlapping: the trailing 1 of a match SHALL count as the first bit of the next pattern.
REQ-013 match SHALL go high in the cycle after the edge that samples the fourth pattern bit, for exactly one cycle per detection.
REQ-014 Back-to-back detections with a gap of zero invalid cycles SHALL each produce their own pulse.
REQ-015 When in_valid=0, state and count SHALL hold and match SHALL be 0 next cycle.
REQ-016 On each detection, count SHALL increment by 1 unless already 2^CNT_W-1, where it SHALL hold; it SHALL never wrap to 0.
REQ-017 match SHALL still pulse when count is saturated.
REQ-018 sat SHALL be a combinational decode of the registered count, with no added latency.
REQ-019 clear=1 SHALL force next state S0, count 0, match 0, taking priority over in_valid and any simultaneous detection.
REQ-020 The bit presented with clear=1 SHALL be discarded, not used as the first stream bit.
REQ-021 Unused state encodings SHALL not arise; any illegal state, if reached, SHALL go to S0 on the next valid bit.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force state S0, match 0, count 0, and sat 0.
REQ-023 Reset asserted mid-pattern SHALL discard the partial pattern; detection restarts from S0 after release.
REQ-024 The first rising edge after rst falls SHALL sample in_bit normally.

Structure
REQ-025 State encodings S0..S3 and the pattern constant 4'b1011 SHALL live in a shared include file for reuse by the bench.
REQ-026 One sub-module dff_ar (1-bit D flip-flop with asynchronous active-high reset and enable) SHALL be used for all state, match and count bits.
REQ-027 Next-state and counter-increment logic SHALL be combinational, built from the team's basic gate modules (AND, OR, NOT, XOR).

Verification
REQ-028 After reset, feed valid bits 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7, count=2, sat=0.
REQ-029 Feed 1,0,1,0,1,1 -> single match after bit 6 (S3 on 0 goes to S2), count=1.
REQ-030 Feed 1,0,1 then hold in_valid=0 for 5 cycles, then valid 1 -> no match during the gap, one match after the last bit.
REQ-031 Drive 18 overlapping detections with CNT_W=4 -> count stops at 15, sat=1 from the 15th detection, match pulses all 18 times.
REQ-032 Drive clear=1 on the cycle of the fourth bit of 1011 with count=3 -> match stays 0, count=0, state S0.
REQ-033 Assert rst asynchronously between edges while in S3 with count=5 -> count, match and sat drop to 0 before the next edge; a following 1 gives no match.
